// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, word/index types for the 8x16 register file.
// Rev 1.0 -- REG_FILE_ZERO_REG_EN hardwires register 0 to zero.
`default_nettype none

package reg_file_pkg;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int NUM_REGS   = 1 << DEF_ADDR_W;

  typedef logic [DEF_WIDTH-1:0]  word_t;
  typedef logic [DEF_ADDR_W-1:0] idx_t;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif
endpackage

`default_nettype wire

// File: rtl/reg_file_port.sv
// reg_file_port: tri-state read driver and one-hot write-enable decode for one port.
// Rev 1.0
`default_nettype none

module reg_file_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int NUM   = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0] sel,
  input  logic              read,
  input  logic [WIDTH-1:0]  regs [NUM],
  inout  wire  [WIDTH-1:0]  data,
  output logic [NUM-1:0]    we,
  output logic [WIDTH-1:0]  wdata
);

  assign data  = read ? regs[sel] : {WIDTH{1'bz}};
  assign wdata = data;

  always_comb begin
    we = '0;
    if (!read) we[sel] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// reg_file: 8x16 register file, two bidirectional ports, falling-edge writes, async reset.
// Rev 1.0 -- define REG_FILE_ZERO_REG_EN to hardwire register 0 to zero.
`default_nettype none

module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a,
  input  logic              a_read,
  inout  wire  [WIDTH-1:0]  a_data,
  input  logic [ADDR_W-1:0] b,
  input  logic              b_read,
  inout  wire  [WIDTH-1:0]  b_data
);

  localparam int NUM = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [NUM];
  logic [NUM-1:0]   we_a, we_b;
  logic [WIDTH-1:0] wd_a, wd_b;

  reg_file_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_port_a (
    .sel   (a),
    .read  (a_read),
    .regs  (regs),
    .data  (a_data),
    .we    (we_a),
    .wdata (wd_a)
  );

  reg_file_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_port_b (
    .sel   (b),
    .read  (b_read),
    .regs  (regs),
    .data  (b_data),
    .we    (we_b),
    .wdata (wd_b)
  );

  for (genvar i = 0; i < NUM; i++) begin : g_reg
    if (ZERO_REG_EN && i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] q;
      // Port B is checked first so it wins a same-register collision.
      always_ff @(negedge clk0 or posedge reset) begin
        if (reset)        q <= '0;
        else if (we_b[i]) q <= wd_b;
        else if (we_a[i]) q <= wd_a;
      end
      assign regs[i] = q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// tb_reg_file: vector table, directed corner sequences and random traffic vs. an array model.
`default_nettype none

module tb_reg_file;
  import reg_file_pkg::*;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic  clk0 = 1'b0;
  logic  reset;
  idx_t  a, b;
  logic  a_read, b_read;
  word_t a_drv, b_drv;
  wire [DEF_WIDTH-1:0] a_data, b_data;

  assign a_data = a_read ? {DEF_WIDTH{1'bz}} : a_drv;
  assign b_data = b_read ? {DEF_WIDTH{1'bz}} : b_drv;

  reg_file dut (
    .clk0   (clk0),
    .reset  (reset),
    .a      (a),
    .a_read (a_read),
    .a_data (a_data),
    .b      (b),
    .b_read (b_read),
    .b_data (b_data)
  );

  always #5 clk0 = ~clk0;

  int    errors = 0;
  int    checks = 0;
  word_t model [NUM_REGS];

  typedef struct {
    idx_t  a;  logic ar; word_t ad;
    idx_t  b;  logic br; word_t bd;
    logic  ca; word_t ea;
    logic  cb; word_t eb;
  } vec_t;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input idx_t ia, input logic iar, input word_t iad,
                       input idx_t ib, input logic ibr, input word_t ibd);
    a = ia; a_read = iar; a_drv = iad;
    b = ib; b_read = ibr; b_drv = ibd;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  // Storage behaviour: nothing lands during reset, B overwrites A, r0 optionally frozen.
  task automatic commit_model();
    if (!reset) begin
      if (!a_read && !(ZERO && a == 0)) model[a] = a_drv;
      if (!b_read && !(ZERO && b == 0)) model[b] = b_drv;
    end
  endtask

  task automatic check_reads(input string tag);
    if (a_read) check({tag, "_a"}, a_data, model[a]);
    if (b_read) check({tag, "_b"}, b_data, model[b]);
  endtask

  task automatic cycle(input idx_t ia, input logic iar, input word_t iad,
                       input idx_t ib, input logic ibr, input word_t ibd,
                       input string tag);
    @(posedge clk0);
    #1 drive(ia, iar, iad, ib, ibr, ibd);
    #2 check_reads({tag, "_pre"});
    @(negedge clk0);
    commit_model();
    #1 check_reads({tag, "_post"});
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{a:3'd0, ar:1'b0, ad:16'hABCD, b:3'd1, br:1'b0, bd:16'h1234,
                ca:1'b0, ea:16'h0, cb:1'b0, eb:16'h0};
    vecs[1] = '{a:3'd1, ar:1'b1, ad:16'h0, b:3'd0, br:1'b1, bd:16'h0,
                ca:1'b1, ea:16'h1234, cb:1'b1, eb:(ZERO ? 16'h0000 : 16'hABCD)};
    vecs[2] = '{a:3'd5, ar:1'b0, ad:16'h1111, b:3'd5, br:1'b0, bd:16'h2222,
                ca:1'b0, ea:16'h0, cb:1'b0, eb:16'h0};
    vecs[3] = '{a:3'd5, ar:1'b1, ad:16'h0, b:3'd5, br:1'b1, bd:16'h0,
                ca:1'b1, ea:16'h2222, cb:1'b1, eb:16'h2222};
    vecs[4] = '{a:3'd0, ar:1'b0, ad:16'hFFFF, b:3'd3, br:1'b0, bd:16'h0F0F,
                ca:1'b0, ea:16'h0, cb:1'b0, eb:16'h0};
    vecs[5] = '{a:3'd0, ar:1'b1, ad:16'h0, b:3'd3, br:1'b1, bd:16'h0,
                ca:1'b1, ea:(ZERO ? 16'h0000 : 16'hFFFF), cb:1'b1, eb:16'h0F0F};

    clear_model();
    reset = 1'b1;
    drive(3'd0, 1'b1, 16'h0, 3'd0, 1'b1, 16'h0);

    // Writes attempted during reset must not land.
    cycle(3'd2, 1'b0, 16'hFFFF, 3'd6, 1'b0, 16'h5A5A, "rst_wr");
    for (int i = 0; i < NUM_REGS; i++)
      cycle(idx_t'(i), 1'b1, 16'h0, idx_t'(NUM_REGS - 1 - i), 1'b1, 16'h0, "rst_rd");

    @(posedge clk0);
    #1 reset = 1'b0;
    cycle(3'd2, 1'b1, 16'h0, 3'd6, 1'b1, 16'h0, "after_rst");
    check("after_rst_r2", a_data, 16'h0000);
    check("after_rst_r6", b_data, 16'h0000);

    foreach (vecs[i]) begin
      cycle(vecs[i].a, vecs[i].ar, vecs[i].ad, vecs[i].b, vecs[i].br, vecs[i].bd, "vec");
      if (vecs[i].ca) check($sformatf("vec%0d_a", i), a_data, vecs[i].ea);
      if (vecs[i].cb) check($sformatf("vec%0d_b", i), b_data, vecs[i].eb);
    end

    // Write-through timing: B reading 7 while A writes it.
    cycle(3'd7, 1'b0, 16'h1357, 3'd0, 1'b1, 16'h0, "preload7");
    @(posedge clk0);
    #1 drive(3'd7, 1'b0, 16'hBEEF, 3'd7, 1'b1, 16'h0);
    #2 check("timing_old", b_data, 16'h1357);
    @(negedge clk0);
    commit_model();
    #1 check("timing_new", b_data, 16'hBEEF);

    // Asynchronous reset between edges.
    cycle(3'd5, 1'b0, 16'hC0DE, 3'd4, 1'b0, 16'h7777, "load");
    @(posedge clk0);
    #1 drive(3'd5, 1'b1, 16'h0, 3'd7, 1'b1, 16'h0);
    #1 check("pre_async_a", a_data, 16'hC0DE);
    check("pre_async_b", b_data, 16'hBEEF);
    reset = 1'b1;
    clear_model();
    #1 check("async_rst_a", a_data, 16'h0000);
    check("async_rst_b", b_data, 16'h0000);
    reset = 1'b0;
    cycle(3'd4, 1'b1, 16'h0, 3'd1, 1'b1, 16'h0, "post_async");

    for (int n = 0; n < 300; n++)
      cycle(idx_t'($urandom_range(0, NUM_REGS - 1)), 1'($urandom_range(0, 1)), word_t'($urandom),
            idx_t'($urandom_range(0, NUM_REGS - 1)), 1'($urandom_range(0, 1)), word_t'($urandom),
            "rand");

    for (int i = 0; i < NUM_REGS; i++)
      cycle(idx_t'(i), 1'b1, 16'h0, idx_t'(i), 1'b1, 16'h0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
